// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define MC_IMM_LOGIC_EN to add andi/ori/slti support through a dedicated IMM_EX state.
module mips_mc_ctrl #(
  parameter int ALU_CW  = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [ALU_CW-1:0]  alu_control,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RTYPE_EX = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_RTYPE_WB = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQ_EX   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ADDI_EX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IMM_WB   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_J_EX     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_IMM_EX   = STATE_W'(12);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALU_CW-1:0] ALU_AND = ALU_CW'(0);
  localparam logic [ALU_CW-1:0] ALU_OR  = ALU_CW'(1);
  localparam logic [ALU_CW-1:0] ALU_ADD = ALU_CW'(2);
  localparam logic [ALU_CW-1:0] ALU_SUB = ALU_CW'(6);
  localparam logic [ALU_CW-1:0] ALU_SLT = ALU_CW'(7);
  localparam logic [ALU_CW-1:0] ALU_NOR = ALU_CW'(12);

  logic [STATE_W-1:0] state_q, next_state;
  logic              mem_req_d, mem_write_d, iord_d, ir_write_d, reg_write_d;
  logic              reg_dst_d, mem_to_reg_d, alu_src_a_d, pc_en_d, illegal_d;
  logic [1:0]        alu_src_b_d, pc_src_d;
  logic [ALU_CW-1:0] alu_control_d;
`ifdef MC_IMM_LOGIC_EN
  logic              ext_zero_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state    = S_FETCH;
    mem_req_d     = 1'b0;
    mem_write_d   = 1'b0;
    iord_d        = 1'b0;
    ir_write_d    = 1'b0;
    reg_write_d   = 1'b0;
    reg_dst_d     = 1'b0;
    mem_to_reg_d  = 1'b0;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 2'b00;
    alu_control_d = ALU_ADD;
    pc_src_d      = 2'b00;
    pc_en_d       = 1'b0;
    illegal_d     = 1'b0;
`ifdef MC_IMM_LOGIC_EN
    ext_zero_d    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req_d   = 1'b1;
        alu_src_b_d = 2'b01;
        ir_write_d  = mem_ready;
        pc_en_d     = mem_ready;
        next_state  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // The adder precomputes PC + (imm << 2) here for a possible branch.
        alu_src_b_d = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPE_EX;
          OP_BEQ:       next_state = S_BEQ_EX;
          OP_ADDI:      next_state = S_ADDI_EX;
          OP_J:         next_state = S_J_EX;
`ifdef MC_IMM_LOGIC_EN
          OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IMM_EX;
`endif
          default: begin
            illegal_d  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        next_state  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_d  = 1'b1;
        iord_d     = 1'b1;
        next_state = mem_ready ? S_MEM_WB : S_MEMRD;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
        next_state  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        alu_src_a_d = 1'b1;
        next_state  = S_RTYPE_WB;
        case (funct)
          6'h20:   alu_control_d = ALU_ADD;
          6'h22:   alu_control_d = ALU_SUB;
          6'h24:   alu_control_d = ALU_AND;
          6'h25:   alu_control_d = ALU_OR;
          6'h2A:   alu_control_d = ALU_SLT;
          6'h27:   alu_control_d = ALU_NOR;
          default: begin
            illegal_d  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_RTYPE_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a_d   = 1'b1;
        alu_control_d = ALU_SUB;
        pc_src_d      = 2'b01;
        pc_en_d       = zero;
      end
      S_ADDI_EX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        next_state  = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write_d = 1'b1;
      end
      S_J_EX: begin
        pc_src_d = 2'b10;
        pc_en_d  = 1'b1;
      end
`ifdef MC_IMM_LOGIC_EN
      S_IMM_EX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        next_state  = S_IMM_WB;
        case (opcode)
          OP_ANDI: begin
            alu_control_d = ALU_AND;
            ext_zero_d    = 1'b1;
          end
          OP_ORI: begin
            alu_control_d = ALU_OR;
            ext_zero_d    = 1'b1;
          end
          default: alu_control_d = ALU_SLT;
        endcase
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // Outputs are forced to their reset values while rst_n is low so mem_req drops immediately.
  assign mem_req     = rst_n & mem_req_d;
  assign mem_write   = rst_n & mem_write_d;
  assign iord        = rst_n & iord_d;
  assign ir_write    = rst_n & ir_write_d;
  assign reg_write   = rst_n & reg_write_d;
  assign reg_dst     = rst_n & reg_dst_d;
  assign mem_to_reg  = rst_n & mem_to_reg_d;
  assign alu_src_a   = rst_n & alu_src_a_d;
  assign alu_src_b   = rst_n ? alu_src_b_d : 2'b01;
  assign alu_control = rst_n ? alu_control_d : ALU_ADD;
  assign pc_src      = rst_n ? pc_src_d : 2'b00;
  assign pc_en       = rst_n & pc_en_d;
  assign illegal_op  = rst_n & illegal_d;
  assign state       = state_q;
`ifdef MC_IMM_LOGIC_EN
  assign ext_zero    = rst_n & ext_zero_d;
`else
  assign ext_zero    = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-instruction expected control traces built from
// the instruction semantics, driven with directed and randomized instructions and stalls.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_zero, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control;
  logic [3:0] state;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
  } outs_t;

  outs_t exp_q[$];
  bit    rdy_q[$];
  int    tests = 0;
  int    fails = 0;

  mips_mc_ctrl #(.ALU_CW(4), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic outs_t idle();
    outs_t o = '0;
    o.alu_control = 4'd2;
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.mem_req = mem_req;       o.mem_write = mem_write;   o.iord = iord;
    o.ir_write = ir_write;     o.reg_write = reg_write;   o.reg_dst = reg_dst;
    o.mem_to_reg = mem_to_reg; o.alu_src_a = alu_src_a;   o.alu_src_b = alu_src_b;
    o.ext_zero = ext_zero;     o.alu_control = alu_control;
    o.pc_src = pc_src;         o.pc_en = pc_en;           o.illegal_op = illegal_op;
    return o;
  endfunction

  function automatic bit imm_en();
`ifdef MC_IMM_LOGIC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // ALU code for an R-type funct, or -1 when the funct is unsupported.
  function automatic int rt_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      6'h27: return 12;
      default: return -1;
    endcase
  endfunction

  function automatic void push(input outs_t o, input bit rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endfunction

  // Build the cycle-by-cycle expected control trace of one instruction.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                input int fs, input int ms);
    outs_t o;
    bit    legal;
    bit    imm_op;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < fs; i++) begin
      o = idle(); o.mem_req = 1; o.alu_src_b = 2'b01;
      push(o, 1'b0);
    end
    o = idle(); o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = 1; o.pc_en = 1;
    push(o, 1'b1);
    imm_op = imm_en() && (op == 6'h0C || op == 6'h0D || op == 6'h0A);
    legal = (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 ||
             op == 6'h08 || op == 6'h02 || imm_op);
    o = idle(); o.alu_src_b = 2'b11; o.illegal_op = !legal;
    push(o, 1'($urandom_range(0, 1)));
    if (!legal) return;
    if (op == 6'h23 || op == 6'h2B) begin
      o = idle(); o.alu_src_a = 1; o.alu_src_b = 2'b10;
      push(o, 1'($urandom_range(0, 1)));
      for (int i = 0; i <= ms; i++) begin
        o = idle(); o.mem_req = 1; o.iord = 1; o.mem_write = (op == 6'h2B);
        push(o, i == ms);
      end
      if (op == 6'h23) begin
        o = idle(); o.reg_write = 1; o.mem_to_reg = 1;
        push(o, 1'($urandom_range(0, 1)));
      end
    end else if (op == 6'h00) begin
      o = idle(); o.alu_src_a = 1; o.alu_src_b = 2'b00;
      if (rt_alu(fn) < 0) o.illegal_op = 1;
      else o.alu_control = 4'(rt_alu(fn));
      push(o, 1'($urandom_range(0, 1)));
      if (rt_alu(fn) >= 0) begin
        o = idle(); o.reg_write = 1; o.reg_dst = 1;
        push(o, 1'($urandom_range(0, 1)));
      end
    end else if (op == 6'h04) begin
      o = idle(); o.alu_src_a = 1; o.alu_control = 4'd6; o.pc_src = 2'b01; o.pc_en = z;
      push(o, 1'($urandom_range(0, 1)));
    end else if (op == 6'h02) begin
      o = idle(); o.pc_src = 2'b10; o.pc_en = 1;
      push(o, 1'($urandom_range(0, 1)));
    end else begin
      o = idle(); o.alu_src_a = 1; o.alu_src_b = 2'b10;
      if (op == 6'h0C) begin o.alu_control = 4'd0; o.ext_zero = 1; end
      if (op == 6'h0D) begin o.alu_control = 4'd1; o.ext_zero = 1; end
      if (op == 6'h0A) o.alu_control = 4'd7;
      push(o, 1'($urandom_range(0, 1)));
      o = idle(); o.reg_write = 1;
      push(o, 1'($urandom_range(0, 1)));
    end
  endfunction

  // Runs one instruction from FETCH (caller is at posedge+1); lim < 0 runs it to completion.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fs, input int ms, input int lim, input string tag);
    int    n;
    outs_t obs;
    build(op, fn, z, fs, ms);
    opcode = op;
    funct = fn;
    zero = z;
    n = (lim < 0 || lim > exp_q.size()) ? exp_q.size() : lim;
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q[i];
      @(negedge clk);
      obs = observed();
      tests++;
      if (obs !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL %s op=%h fn=%h cycle %0d: got %h expected %h",
                 tag, op, fn, i, obs, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    outs_t want = idle();
    want.alu_src_b = 2'b01;
    tests++;
    if (observed() !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed(), want);
    end
  endtask

  task automatic test_reset();
    check_reset_vals("reset_values");
    rst_n = 1'b1;
    run_instr(6'h02, 6'h00, 1'b0, 1, 0, -1, "after_reset_j");
    // Abort a load while it waits for memory.
    run_instr(6'h23, 6'h00, 1'b0, 0, 5, 5, "lw_before_reset");
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_memrd");
    @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1, "addi_after_reset");
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'h00, 1'b0, 0, 0, -1, "lw_fast");
    run_instr(6'h23, 6'h00, 1'b1, 2, 1, -1, "lw_stall");
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    foreach (fns[i]) run_instr(6'h00, fns[i], 1'b0, 0, 0, -1, "rtype");
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1, "beq_not_taken");
  endtask

  task automatic test_sw_stall();
    run_instr(6'h2B, 6'h00, 1'b0, 0, 3, -1, "sw_stall3");
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0, -1, "sw_fast");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1, "illegal_opcode");
    run_instr(6'h00, 6'h01, 1'b0, 0, 0, -1, "illegal_funct");
    run_instr(6'h0D, 6'h00, 1'b0, 0, 0, -1, "ori");
    run_instr(6'h0C, 6'h00, 1'b0, 0, 0, -1, "andi");
    run_instr(6'h0A, 6'h00, 1'b0, 0, 0, -1, "slti");
  endtask

  task automatic test_random();
    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02,
                             6'h0C, 6'h0D, 6'h0A, 6'h3F, 6'h00};
    logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    logic [5:0] op, fn;
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1, "b2b_j");
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1, "b2b_beq");
    run_instr(6'h23, 6'h00, 1'b0, 0, 0, -1, "b2b_lw");
    run_instr(6'h3F, 6'h00, 1'b0, 2, 0, 1, "b2b_final_fetch");
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_stall();
    test_illegal();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
